// File: rtl/datapath_units_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_units_pkg : shared width default and shift-direction codes   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package datapath_units_pkg;

    localparam int   WIDTH_DEF = 4;
    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

endpackage : datapath_units_pkg
`default_nettype wire

// File: rtl/adder_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_unit : combinational ripple-carry adder with carry in/out       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module adder_unit
    import datapath_units_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    input  logic             add_cin,
    output logic [WIDTH-1:0] add_s,
    output logic             add_cout
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = add_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_fa (
            .a    (add_a[i]),
            .b    (add_b[i]),
            .cin  (w_carry[i]),
            .s    (add_s[i]),
            .cout (w_carry[i+1])
        );
    end

    assign add_cout = w_carry[WIDTH];

endmodule : adder_unit
`default_nettype wire

// File: rtl/comparator_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | comparator_unit : unsigned magnitude comparator, one-hot gt/lt/eq     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module comparator_unit
    import datapath_units_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] cmp_x,
    input  logic [WIDTH-1:0] cmp_y,
    output logic             cmp_gt,
    output logic             cmp_lt,
    output logic             cmp_eq
);

    // Operands are logic vectors, so the relational compare is unsigned.
    assign cmp_gt = (cmp_x >  cmp_y);
    assign cmp_lt = (cmp_x <  cmp_y);
    assign cmp_eq = (cmp_x == cmp_y);

endmodule : comparator_unit
`default_nettype wire

// File: rtl/full_adder_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | full_adder_cell : one-bit full adder used as the ripple-chain cell    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : full_adder_cell
`default_nettype wire

// File: rtl/shift_reg_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_reg_unit : registered one-position shift of the presented word  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module shift_reg_unit
    import datapath_units_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sr_i,
    input  logic             sr_din,
    input  logic             sr_dir,
    output logic [WIDTH-1:0] sr_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_next;

    // Shifts the incoming word, not r_q: there is no hold or recirculate path.
    always_comb begin
        w_next = {sr_din, sr_i[WIDTH-1:1]};
        if (sr_dir == DIR_LEFT) begin
            w_next = {sr_i[WIDTH-2:0], sr_din};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign sr_q = r_q;

endmodule : shift_reg_unit
`default_nettype wire

// File: rtl/datapath_units.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | datapath_units : shifter, ripple adder and comparator side by side    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module datapath_units
    import datapath_units_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sr_i,
    input  logic             sr_din,
    input  logic             sr_dir,
    output logic [WIDTH-1:0] sr_q,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    input  logic             add_cin,
    output logic [WIDTH-1:0] add_s,
    output logic             add_cout,
    input  logic [WIDTH-1:0] cmp_x,
    input  logic [WIDTH-1:0] cmp_y,
    output logic             cmp_gt,
    output logic             cmp_lt,
    output logic             cmp_eq
);

    shift_reg_unit #(.WIDTH(WIDTH)) u_shift (
        .clk    (clk),
        .rst    (rst),
        .sr_i   (sr_i),
        .sr_din (sr_din),
        .sr_dir (sr_dir),
        .sr_q   (sr_q)
    );

    adder_unit #(.WIDTH(WIDTH)) u_add (
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout)
    );

    comparator_unit #(.WIDTH(WIDTH)) u_cmp (
        .cmp_x  (cmp_x),
        .cmp_y  (cmp_y),
        .cmp_gt (cmp_gt),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq)
    );

endmodule : datapath_units
`default_nettype wire

// File: tb/tb_datapath_units.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_datapath_units : directed vector table plus reset sequences        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_datapath_units;

    localparam int C_W = 4;

    logic           clk;
    logic           rst;
    logic [C_W-1:0] sr_i;
    logic           sr_din;
    logic           sr_dir;
    logic [C_W-1:0] sr_q;
    logic [C_W-1:0] add_a;
    logic [C_W-1:0] add_b;
    logic           add_cin;
    logic [C_W-1:0] add_s;
    logic           add_cout;
    logic [C_W-1:0] cmp_x;
    logic [C_W-1:0] cmp_y;
    logic           cmp_gt;
    logic           cmp_lt;
    logic           cmp_eq;

    int n_cmp = 0;
    int n_err = 0;

    datapath_units #(.WIDTH(C_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sr_i     (sr_i),
        .sr_din   (sr_din),
        .sr_dir   (sr_dir),
        .sr_q     (sr_q),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .cmp_x    (cmp_x),
        .cmp_y    (cmp_y),
        .cmp_gt   (cmp_gt),
        .cmp_lt   (cmp_lt),
        .cmp_eq   (cmp_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, b;
        logic       cin;
        logic [4:0] exp_sum;   // {cout, s}
        logic [3:0] x, y;
        logic [2:0] exp_cmp;   // {gt, lt, eq}
        logic [3:0] si;
        logic       din;
        logic       dir;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        //        a     b     cin  {co,s}    x     y     gle     si       din   dir   q
        vecs[0] = '{4'd6, 4'd10, 1'b0, 5'h10, 4'd6,  4'd10, 3'b010, 4'b0110, 1'b0, 1'b1, 4'b1100};
        vecs[1] = '{4'd7, 4'd8,  1'b1, 5'h10, 4'd9,  4'd9,  3'b001, 4'b1010, 1'b1, 1'b1, 4'b0101};
        vecs[2] = '{4'd3, 4'd4,  1'b1, 5'h08, 4'd15, 4'd0,  3'b100, 4'b0110, 1'b0, 1'b0, 4'b0011};
        vecs[3] = '{4'd0, 4'd0,  1'b0, 5'h00, 4'd8,  4'd7,  3'b100, 4'b1010, 1'b0, 1'b0, 4'b0101};
        vecs[4] = '{4'd15,4'd15, 1'b1, 5'h1F, 4'd0,  4'd15, 3'b010, 4'b1001, 1'b1, 1'b0, 4'b1100};
        vecs[5] = '{4'd5, 4'd2,  1'b0, 5'h07, 4'd12, 4'd3,  3'b100, 4'b1111, 1'b0, 1'b1, 4'b1110};
        vecs[6] = '{4'd9, 4'd6,  1'b0, 5'h0F, 4'd7,  4'd8,  3'b010, 4'b0001, 1'b1, 1'b0, 4'b1000};

        // Reset asserted from time zero with a non-zero word on the shifter input.
        rst = 1'b0; sr_i = 4'b1011; sr_din = 1'b1; sr_dir = 1'b1;
        add_a = '0; add_b = '0; add_cin = 1'b0; cmp_x = '0; cmp_y = '0;
        #1;
        check("reset_q_no_edge", {4'h0, sr_q}, 8'h00);
        @(posedge clk); #1;
        check("reset_q_held_over_edge", {4'h0, sr_q}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("release_q_before_edge", {4'h0, sr_q}, 8'h00);
        @(posedge clk); #1;
        check("first_capture_after_release", {4'h0, sr_q}, 8'h07);   // {011,1}

        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            add_a = vecs[k].a; add_b = vecs[k].b; add_cin = vecs[k].cin;
            cmp_x = vecs[k].x; cmp_y = vecs[k].y;
            sr_i = vecs[k].si; sr_din = vecs[k].din; sr_dir = vecs[k].dir;
            #1;
            check($sformatf("add_v%0d", k), {3'b0, add_cout, add_s}, {3'b0, vecs[k].exp_sum});
            check($sformatf("cmp_v%0d", k), {5'b0, cmp_gt, cmp_lt, cmp_eq}, {5'b0, vecs[k].exp_cmp});
            @(posedge clk); #1;
            check($sformatf("shift_v%0d", k), {4'h0, sr_q}, {4'h0, vecs[k].exp_q});
        end

        // Changes between edges must not reach sr_q.
        #1;
        sr_i = 4'b0000; sr_din = 1'b0; sr_dir = 1'b1;
        #1;
        check("no_change_between_edges", {4'h0, sr_q}, 8'h08);

        // Mid-operation reset pulse between edges.
        @(negedge clk);
        sr_i = 4'b0110; sr_din = 1'b1; sr_dir = 1'b1;
        @(posedge clk); #1;
        check("pre_reset_shift", {4'h0, sr_q}, 8'h0D);                // 1101
        #1 rst = 1'b0;
        #1;
        check("mid_reset_async_clear", {4'h0, sr_q}, 8'h00);
        add_a = 4'd3; add_b = 4'd4; add_cin = 1'b1; cmp_x = 4'd9; cmp_y = 4'd9;
        #1;
        check("add_during_reset", {3'b0, add_cout, add_s}, 8'h08);
        check("cmp_during_reset", {5'b0, cmp_gt, cmp_lt, cmp_eq}, 8'h01);
        @(posedge clk); #1;
        check("mid_reset_held", {4'h0, sr_q}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        sr_i = 4'b0011; sr_din = 1'b1; sr_dir = 1'b0;
        #1;
        check("mid_release_before_edge", {4'h0, sr_q}, 8'h00);
        @(posedge clk); #1;
        check("mid_release_first_capture", {4'h0, sr_q}, 8'h09);     // 1001

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_datapath_units
`default_nettype wire
